// File: rtl/lc3_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : lc3_dmem_responder
// Purpose  : Cycle-accurate LC3 data-memory responder with programmable wait
//            states. Optional address range check: LC3_DMEM_ADDR_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_dmem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        Data_rd,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    output logic [15:0] Data_dout,
    output logic        complete_data
`ifdef LC3_DMEM_ADDR_CHK_EN
    ,
    output logic        addr_err
`endif
);

    localparam int         c_depth = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_wait  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic                    r_rd;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [15:0]             r_din;
    logic                    r_oor;
    logic [15:0]             r_mem [c_depth];

    logic                    w_accept;
    logic                    w_enter_resp;
    logic                    w_in_oor;
    logic                    w_ld_rd;
    logic [DEPTH_LOG2-1:0]   w_ld_idx;
    logic                    w_ld_oor;
    logic                    w_mem_we;

`ifdef LC3_DMEM_ADDR_CHK_EN
    generate
        if (DEPTH_LOG2 < 16) begin : g_oor_chk
            assign w_in_oor = |Data_addr[15:DEPTH_LOG2];
        end else begin : g_oor_none
            assign w_in_oor = 1'b0;
        end
    endgenerate
`else
    // Upper address bits are intentionally ignored: the array wraps.
    logic w_unused_addr;
    assign w_unused_addr = ^Data_addr;
    assign w_in_oor      = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && req_valid;

    // ------------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_cnt_nxt   = c_wait;
                    w_state_nxt = (c_wait == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd  <= 1'b0;
            r_idx <= '0;
            r_din <= 16'h0000;
            r_oor <= 1'b0;
        end else if (w_accept) begin
            r_rd  <= Data_rd;
            r_idx <= Data_addr[DEPTH_LOG2-1:0];
            r_din <= Data_din;
            r_oor <= w_in_oor;
        end
    end

    // With zero wait states RESP is entered on the acceptance edge itself,
    // so the read must use the live inputs rather than the capture registers.
    assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);
    assign w_ld_rd      = (r_state == IDLE) ? Data_rd                    : r_rd;
    assign w_ld_idx     = (r_state == IDLE) ? Data_addr[DEPTH_LOG2-1:0]  : r_idx;
    assign w_ld_oor     = (r_state == IDLE) ? w_in_oor                   : r_oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Data_dout <= 16'h0000;
        end else if (w_enter_resp && w_ld_rd) begin
            Data_dout <= w_ld_oor ? 16'h0000 : r_mem[w_ld_idx];
        end
    end

    // ------------------------------------------------------------------------
    // Storage: not reset; the write commits on the edge leaving RESP, which
    // reset pre-empts by forcing the state back to IDLE.
    // ------------------------------------------------------------------------
    assign w_mem_we = (r_state == RESP) && !r_rd && !r_oor;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_din;
        end
    end

    assign complete_data = (r_state == RESP);

`ifdef LC3_DMEM_ADDR_CHK_EN
    assign addr_err = (r_state == RESP) && r_oor;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lc3_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_dmem_responder
// Purpose  : Directed bench for lc3_dmem_responder (WAIT_STATES=2 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_dmem_responder;

    localparam int c_wa = 2;
    localparam int c_wb = 0;
`ifdef LC3_DMEM_ADDR_CHK_EN
    localparam bit c_chk = 1'b1;
`else
    localparam bit c_chk = 1'b0;
`endif
    localparam logic [15:0] c_alias = c_chk ? 16'h0000 : 16'hAAAA;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, rd_a, cmp_a;
    logic [15:0] addr_a, din_a, dout_a;
    logic        req_b, rd_b, cmp_b;
    logic [15:0] addr_b, din_b, dout_b;
`ifdef LC3_DMEM_ADDR_CHK_EN
    logic        err_a, err_b;
`endif

    always #5 clk = ~clk;

    lc3_dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(c_wa)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_a), .Data_rd(rd_a),
        .Data_addr(addr_a), .Data_din(din_a), .Data_dout(dout_a),
        .complete_data(cmp_a)
`ifdef LC3_DMEM_ADDR_CHK_EN
        , .addr_err(err_a)
`endif
    );

    lc3_dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(c_wb)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_b), .Data_rd(rd_b),
        .Data_addr(addr_b), .Data_din(din_b), .Data_dout(dout_b),
        .complete_data(cmp_b)
`ifdef LC3_DMEM_ADDR_CHK_EN
        , .addr_err(err_b)
`endif
    );

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic rd,
                         input logic [15:0] addr, input logic [15:0] din);
        if (sel) begin
            req_b = v; rd_b = rd; addr_b = addr; din_b = din;
        end else begin
            req_a = v; rd_a = rd; addr_a = addr; din_a = din;
        end
    endtask

    // Issues one access; caller is 1 time unit past an edge with the DUT idle.
    task automatic access(input bit sel, input logic rd, input logic [15:0] addr,
                          input logic [15:0] din, input bit scramble, input bit hold,
                          output int lat, output logic [15:0] dout, output logic err);
        bit done;
        done = 1'b0;
        lat  = 0;
        err  = 1'b0;
        drive(sel, 1'b1, rd, addr, din);
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                if (scramble) drive(sel, 1'b0, rd, addr ^ 16'h0001, 16'h9999);
                else          drive(sel, 1'b0, rd, addr, din);
            end
            if ((sel ? cmp_b : cmp_a) === 1'b1) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL timeout: no complete_data after %0d cycles, want 1", lat);
        end
        dout = sel ? dout_b : dout_a;
`ifdef LC3_DMEM_ADDR_CHK_EN
        err  = sel ? err_b : err_a;
`endif
        if (hold) drive(sel, 1'b1, rd, addr, din);
        @(posedge clk); #1;
        check("pulse_width", {15'd0, sel ? cmp_b : cmp_a}, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [15:0] dout;
        logic        err;

        vecs[0]  = '{1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b0, 16'h0011, 16'h1357, 16'hBEEF, 1'b0};
        vecs[3]  = '{1'b1, 16'h0011, 16'h0000, 16'h1357, 1'b0};
        vecs[4]  = '{1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[5]  = '{1'b0, 16'h0005, 16'h0A05, 16'hBEEF, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 16'h0000, 16'hBEEF, 1'b0};
        vecs[7]  = '{1'b0, 16'h0100, 16'hAAAA, 16'hBEEF, c_chk};
        vecs[8]  = '{1'b1, 16'h0000, 16'h0000, c_alias,  1'b0};
        vecs[9]  = '{1'b1, 16'h0100, 16'h0000, c_alias,  c_chk};
        vecs[10] = '{1'b0, 16'h00FF, 16'hFFFF, c_alias,  1'b0};
        vecs[11] = '{1'b1, 16'h00FF, 16'h0000, 16'hFFFF, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout_a", dout_a, 16'h0000);
        check("reset_dout_b", dout_b, 16'h0000);
        check("reset_cmp_a", {15'd0, cmp_a}, 16'h0000);
        check("reset_cmp_b", {15'd0, cmp_b}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            access(1'b0, vecs[i].rd, vecs[i].addr, vecs[i].din, 1'b0, 1'b0, lat, dout, err);
            check($sformatf("vec%0d_latency", i), 16'(lat), 16'(c_wa + 1));
            check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
`ifdef LC3_DMEM_ADDR_CHK_EN
            check($sformatf("vec%0d_addr_err", i), {15'd0, err}, {15'd0, vecs[i].exp_err});
`endif
        end

        // Held req_valid: not re-accepted on the edge leaving RESP, only in IDLE.
        access(1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0, 1'b1, lat, dout, err);
        check("hold_first_dout", dout, 16'h0A05);
        access(1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0, 1'b0, lat, dout, err);
        check("hold_second_latency", 16'(lat), 16'(c_wa + 1));
        check("hold_second_dout", dout, 16'h0A05);

        // Inputs changing during WAIT must be ignored.
        access(1'b0, 1'b0, 16'h0031, 16'h1111, 1'b0, 1'b0, lat, dout, err);
        access(1'b0, 1'b0, 16'h0030, 16'h5555, 1'b1, 1'b0, lat, dout, err);
        check("scramble_latency", 16'(lat), 16'(c_wa + 1));
        access(1'b0, 1'b1, 16'h0030, 16'h0000, 1'b0, 1'b0, lat, dout, err);
        check("scramble_target", dout, 16'h5555);
        access(1'b0, 1'b1, 16'h0031, 16'h0000, 1'b0, 1'b0, lat, dout, err);
        check("scramble_untouched", dout, 16'h1111);

        // Zero wait states, back-to-back write/read pairs.
        access(1'b1, 1'b0, 16'h0020, 16'h1234, 1'b0, 1'b0, lat, dout, err);
        check("w0_write1_latency", 16'(lat), 16'(c_wb + 1));
        access(1'b1, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b0, lat, dout, err);
        check("w0_read1_latency", 16'(lat), 16'(c_wb + 1));
        check("w0_read1_dout", dout, 16'h1234);
        access(1'b1, 1'b0, 16'h0020, 16'h4321, 1'b0, 1'b0, lat, dout, err);
        check("w0_write2_dout_held", dout, 16'h1234);
        access(1'b1, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b0, lat, dout, err);
        check("w0_read2_latency", 16'(lat), 16'(c_wb + 1));
        check("w0_read2_dout", dout, 16'h4321);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("w0_idle_no_cmp", {15'd0, cmp_b}, 16'h0000);
        end

        // Reset asserted mid-WAIT drops the pending write.
        access(1'b0, 1'b0, 16'h0040, 16'h2222, 1'b0, 1'b0, lat, dout, err);
        drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h7777);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0040, 16'h7777);
        rst_n = 1'b0;
        #1;
        check("midreset_cmp", {15'd0, cmp_a}, 16'h0000);
        check("midreset_dout", dout_a, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postreset_cmp", {15'd0, cmp_a}, 16'h0000);
        access(1'b0, 1'b0, 16'h0041, 16'h3333, 1'b0, 1'b0, lat, dout, err);
        check("postreset_write_latency", 16'(lat), 16'(c_wa + 1));
        check("postreset_dout", dout, 16'h0000);
        access(1'b0, 1'b1, 16'h0040, 16'h0000, 1'b0, 1'b0, lat, dout, err);
        check("dropped_write", dout, 16'h2222);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
